// File: rtl/board_pkg.sv
// Shared board constants: geometry, cell colours, request indices and the
// write arbiter's state encoding.
package board_pkg;

   localparam int GRID_W = 16;

   localparam logic [2:0] EMPTY     = 3'b000;
   localparam logic [2:0] RED       = 3'b100;
   localparam logic [2:0] BLUE      = 3'b001;
   localparam logic [2:0] RED_BOMB  = 3'b110;
   localparam logic [2:0] BLUE_BOMB = 3'b011;
   localparam logic [2:0] COLLIDE   = 3'b111;

   typedef enum logic [1:0] {
      REQ_RED_MOVE  = 2'd0,
      REQ_BLUE_MOVE = 2'd1,
      REQ_RED_BOMB  = 2'd2,
      REQ_BLUE_BOMB = 2'd3
   } req_idx_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      DONE  = 2'd2
   } arb_state_t;

endpackage

// File: rtl/board_pos_to_addr.sv
// Cell coordinate to linear board address (Y*GRID_W + X). Out-of-range
// coordinates pass through unmodified.
module board_pos_to_addr #(
   parameter int GRID_W  = board_pkg::GRID_W,
   parameter int ADDR_W  = 9,
   parameter int COORD_W = 4
) (
   input  logic [COORD_W-1:0] posX,
   input  logic [COORD_W-1:0] posY,
   output logic [ADDR_W-1:0]  address
);

   logic [ADDR_W-1:0] wideX;
   logic [ADDR_W-1:0] wideY;

   assign wideX = ADDR_W'(posX);
   assign wideY = ADDR_W'(posY);

   // Address arithmetic carried out at full address width
   always_comb begin
      address = wideY * ADDR_W'(GRID_W) + wideX;
   end

endmodule

// File: rtl/board_write_arbiter.sv
// Shares the board memory write port between red/blue moves and bombs.
// Pending events are serialised into writes held for HOLD_CYCLES cycles,
// started only while the draw engine is not reading the board.
module board_write_arbiter #(
   parameter int GRID_W      = board_pkg::GRID_W,
   parameter int ADDR_W      = 9,
   parameter int COLOUR_W    = 3,
   parameter int HOLD_CYCLES = 3
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                red_move_req,
   input  logic [3:0]          red_X,
   input  logic [3:0]          red_Y,
   input  logic                blue_move_req,
   input  logic [3:0]          blue_X,
   input  logic [3:0]          blue_Y,
   input  logic                redBombPlaced,
   input  logic [3:0]          redBomb_X,
   input  logic [3:0]          redBomb_Y,
   input  logic                blueBombPlaced,
   input  logic [3:0]          blueBomb_X,
   input  logic [3:0]          blueBomb_Y,
   input  logic                draw_busy,
   output logic [ADDR_W-1:0]   board_address,
   output logic [COLOUR_W-1:0] board_data,
   output logic                board_wren,
   output logic                board_updated,
   output logic                busy,
   output logic [3:0]          pending
);

   import board_pkg::*;

   localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HOLD_CYCLES - 1);

   arb_state_t        state;
   req_idx_t          grantIdx;
   req_idx_t          selIdx;
   logic [CNT_W-1:0]  holdCnt;
   logic              rr;
   logic              lastHold;
   logic              moveCollide;
   logic [3:0]        reqVec;
   logic [3:0]        clrVec;
   logic [3:0]        reqX [4];
   logic [3:0]        reqY [4];
   logic [3:0]        latX [4];
   logic [3:0]        latY [4];
   logic [3:0]        selX;
   logic [3:0]        selY;
   logic [ADDR_W-1:0] selAddr;
   logic [COLOUR_W-1:0] selColour;

   assign reqVec = {blueBombPlaced, redBombPlaced, blue_move_req, red_move_req};
   assign reqX   = '{red_X, blue_X, redBomb_X, blueBomb_X};
   assign reqY   = '{red_Y, blue_Y, redBomb_Y, blueBomb_Y};

   assign lastHold = (state == WRITE) && (holdCnt == LAST_CNT);
   assign busy     = (state != IDLE);

   // Combinational so a request arriving during DONE itself suppresses the pulse
   assign board_updated = (state == DONE) && (pending == '0) && (reqVec == '0);

   // Arbitration: bombs beat moves, rr breaks ties within a class
   always_comb begin
      selIdx = REQ_RED_MOVE;
      if (pending[REQ_RED_BOMB] || pending[REQ_BLUE_BOMB]) begin
         if (pending[REQ_RED_BOMB] && pending[REQ_BLUE_BOMB])
            selIdx = rr ? REQ_BLUE_BOMB : REQ_RED_BOMB;
         else
            selIdx = pending[REQ_RED_BOMB] ? REQ_RED_BOMB : REQ_BLUE_BOMB;
      end else if (pending[REQ_RED_MOVE] && pending[REQ_BLUE_MOVE]) begin
         selIdx = rr ? REQ_BLUE_MOVE : REQ_RED_MOVE;
      end else if (pending[REQ_BLUE_MOVE]) begin
         selIdx = REQ_BLUE_MOVE;
      end
   end

   // Granted source's coordinates and cell colour
   always_comb begin
      selX        = latX[selIdx];
      selY        = latY[selIdx];
      moveCollide = (latX[REQ_RED_MOVE] == latX[REQ_BLUE_MOVE]) &&
                    (latY[REQ_RED_MOVE] == latY[REQ_BLUE_MOVE]);
      case (selIdx)
         REQ_RED_MOVE:  selColour = COLOUR_W'(moveCollide ? COLLIDE : RED);
         REQ_BLUE_MOVE: selColour = COLOUR_W'(moveCollide ? COLLIDE : BLUE);
         REQ_RED_BOMB:  selColour = COLOUR_W'(RED_BOMB);
         default:       selColour = COLOUR_W'(BLUE_BOMB);
      endcase
   end

   board_pos_to_addr #(
      .GRID_W (GRID_W),
      .ADDR_W (ADDR_W),
      .COORD_W(4)
   ) u_posToAddr (
      .posX   (selX),
      .posY   (selY),
      .address(selAddr)
   );

   // Flag to clear on the final hold cycle of the current write
   always_comb begin
      clrVec = '0;
      if (lastHold)
         clrVec[grantIdx] = 1'b1;
   end

   // Request capture: set beats clear, latest coordinates win
   always_ff @(posedge clock) begin
      if (!reset) begin
         pending <= '0;
         latX    <= '{default: '0};
         latY    <= '{default: '0};
      end else begin
         pending <= (pending & ~clrVec) | reqVec;
         for (int unsigned i = 0; i < 4; i++) begin
            if (reqVec[i]) begin
               latX[i] <= reqX[i];
               latY[i] <= reqY[i];
            end
         end
      end
   end

   // Write sequencer: grant in IDLE, hold the write, then one DONE cycle
   always_ff @(posedge clock) begin
      if (!reset) begin
         state         <= IDLE;
         grantIdx      <= REQ_RED_MOVE;
         holdCnt       <= '0;
         rr            <= 1'b0;
         board_address <= '0;
         board_data    <= '0;
         board_wren    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if ((pending != '0) && !draw_busy) begin
                  grantIdx      <= selIdx;
                  board_address <= selAddr;
                  board_data    <= selColour;
                  board_wren    <= 1'b1;
                  holdCnt       <= '0;
                  rr            <= (selIdx == REQ_RED_MOVE) || (selIdx == REQ_RED_BOMB);
                  state         <= WRITE;
               end
            end
            WRITE: begin
               if (lastHold) begin
                  board_wren <= 1'b0;
                  state      <= DONE;
               end else begin
                  holdCnt <= holdCnt + 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               board_wren <= 1'b0;
               state      <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_board_write_arbiter.sv
// Self-checking bench for board_write_arbiter: directed scenarios plus
// randomized traffic, every cycle compared against a behavioural model.
module tb_board_write_arbiter;

   localparam int HOLD = 3;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       red_move_req = 1'b0, blue_move_req = 1'b0;
   logic       redBombPlaced = 1'b0, blueBombPlaced = 1'b0;
   logic [3:0] red_X = '0, red_Y = '0, blue_X = '0, blue_Y = '0;
   logic [3:0] redBomb_X = '0, redBomb_Y = '0, blueBomb_X = '0, blueBomb_Y = '0;
   logic       draw_busy = 1'b0;
   logic [8:0] board_address;
   logic [2:0] board_data;
   logic       board_wren, board_updated, busy;
   logic [3:0] pending;

   int vecCount = 0;
   int errCount = 0;

   // Reference model: event flags, last coordinates, and a write timer
   logic [3:0] mPend = '0;
   int         mX [4];
   int         mY [4];
   bit         mRr = 1'b0;
   int         mMode = 0;   // 0 idle, 1 writing, 2 done
   int         mLeft = 0;
   int         mGnt = 0;
   int         mAddr = 0;
   int         mData = 0;

   board_write_arbiter #(
      .GRID_W(16), .ADDR_W(9), .COLOUR_W(3), .HOLD_CYCLES(HOLD)
   ) dut (
      .clock(clock), .reset(reset),
      .red_move_req(red_move_req), .red_X(red_X), .red_Y(red_Y),
      .blue_move_req(blue_move_req), .blue_X(blue_X), .blue_Y(blue_Y),
      .redBombPlaced(redBombPlaced), .redBomb_X(redBomb_X), .redBomb_Y(redBomb_Y),
      .blueBombPlaced(blueBombPlaced), .blueBomb_X(blueBomb_X), .blueBomb_Y(blueBomb_Y),
      .draw_busy(draw_busy),
      .board_address(board_address), .board_data(board_data),
      .board_wren(board_wren), .board_updated(board_updated),
      .busy(busy), .pending(pending)
   );

   always #5 clock = ~clock;

   task automatic checkVal(input string tag, input int obs, input int exp);
      vecCount++;
      if (obs != exp) begin
         errCount++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int colourOf(input int idx);
      bit same;
      same = (mX[0] == mX[1]) && (mY[0] == mY[1]);
      case (idx)
         0:       return same ? 7 : 4;
         1:       return same ? 7 : 1;
         2:       return 6;
         default: return 3;
      endcase
   endfunction

   task automatic modelStep();
      logic [3:0] rq;
      logic [3:0] clr;
      int g;
      int nx [4];
      int ny [4];
      if (!reset) begin
         mMode = 0; mPend = '0; mRr = 0; mAddr = 0; mData = 0; mLeft = 0;
         for (int i = 0; i < 4; i++) begin mX[i] = 0; mY[i] = 0; end
         return;
      end
      rq  = {blueBombPlaced, redBombPlaced, blue_move_req, red_move_req};
      nx  = '{int'(red_X), int'(blue_X), int'(redBomb_X), int'(blueBomb_X)};
      ny  = '{int'(red_Y), int'(blue_Y), int'(redBomb_Y), int'(blueBomb_Y)};
      clr = '0;
      if (mMode == 0) begin
         if (mPend != 0 && !draw_busy) begin
            if (mPend[2] || mPend[3])
               g = (mPend[2] && mPend[3]) ? (mRr ? 3 : 2) : (mPend[2] ? 2 : 3);
            else
               g = (mPend[0] && mPend[1]) ? (mRr ? 1 : 0) : (mPend[0] ? 0 : 1);
            mGnt  = g;
            mAddr = mY[g] * 16 + mX[g];
            mData = colourOf(g);
            mRr   = (g == 0 || g == 2);
            mLeft = HOLD;
            mMode = 1;
         end
      end else if (mMode == 1) begin
         mLeft--;
         if (mLeft == 0) begin
            clr[mGnt] = 1'b1;
            mMode = 2;
         end
      end else begin
         mMode = 0;
      end
      mPend = (mPend & ~clr) | rq;
      for (int i = 0; i < 4; i++)
         if (rq[i]) begin mX[i] = nx[i]; mY[i] = ny[i]; end
   endtask

   // One clock cycle: compare at negedge, advance model at posedge, drop pulses
   task automatic runCycle();
      logic [3:0] rq;
      @(negedge clock);
      rq = {blueBombPlaced, redBombPlaced, blue_move_req, red_move_req};
      checkVal("wren", board_wren, int'(mMode == 1));
      checkVal("busy", busy, int'(mMode != 0));
      checkVal("updated", board_updated, int'(mMode == 2 && mPend == 0 && rq == 0));
      checkVal("pending", pending, mPend);
      checkVal("address", board_address, mAddr);
      checkVal("data", board_data, mData);
      @(posedge clock);
      modelStep();
      #1;
      red_move_req = 0; blue_move_req = 0; redBombPlaced = 0; blueBombPlaced = 0;
      #1;
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) runCycle();
   endtask

   task automatic resetDut();
      reset = 0; draw_busy = 0;
      runCycle();
      reset = 1;
   endtask

   task automatic redMove(input int x, input int y);
      red_move_req = 1; red_X = 4'(x); red_Y = 4'(y);
   endtask

   task automatic blueMove(input int x, input int y);
      blue_move_req = 1; blue_X = 4'(x); blue_Y = 4'(y);
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin mX[i] = 0; mY[i] = 0; end
      repeat (3) @(posedge clock);
      #2;
      runCycle();
      checkVal("rst_wren", board_wren, 0);
      checkVal("rst_pending", pending, 0);
      checkVal("rst_busy", busy, 0);
      checkVal("rst_address", board_address, 0);
      reset = 1;

      // Single red move
      resetDut();
      redMove(3, 2);
      cycles(2);
      checkVal("s1_wren_c2", board_wren, 1);
      checkVal("s1_addr", board_address, 35);
      checkVal("s1_data", board_data, 3'b100);
      cycles(2);
      checkVal("s1_wren_c4", board_wren, 1);
      cycles(1);
      checkVal("s1_wren_c5", board_wren, 0);
      checkVal("s1_updated", board_updated, 1);
      checkVal("s1_pending", pending, 0);

      // Bomb beats a simultaneous move
      resetDut();
      redBombPlaced = 1; redBomb_X = 5; redBomb_Y = 5;
      blueMove(1, 0);
      cycles(2);
      checkVal("s2_bomb_addr", board_address, 85);
      checkVal("s2_bomb_data", board_data, 3'b110);
      cycles(3);
      checkVal("s2_no_early_update", board_updated, 0);
      cycles(2);
      checkVal("s2_move_wren", board_wren, 1);
      checkVal("s2_move_addr", board_address, 1);
      checkVal("s2_move_data", board_data, 3'b001);
      cycles(3);
      checkVal("s2_updated", board_updated, 1);

      // Collision of both moves, red first; rr returns to red
      resetDut();
      redMove(4, 4); blueMove(4, 4);
      cycles(2);
      checkVal("s3_red_addr", board_address, 68);
      checkVal("s3_red_data", board_data, 3'b111);
      cycles(5);
      checkVal("s3_blue_addr", board_address, 68);
      checkVal("s3_blue_data", board_data, 3'b111);
      cycles(4);
      redMove(1, 1); blueMove(2, 2);
      cycles(2);
      checkVal("s3_rr_addr", board_address, 17);
      checkVal("s3_rr_data", board_data, 3'b100);
      cycles(5);

      // draw_busy gating and hold not shortened mid-write
      resetDut();
      blueMove(2, 3); draw_busy = 1;
      runCycle();
      for (int i = 1; i < 10; i++) begin
         checkVal("s4_blocked", board_wren, 0);
         runCycle();
      end
      checkVal("s4_blocked", board_wren, 0);
      draw_busy = 0;
      runCycle();
      checkVal("s4_start", board_wren, 1);
      checkVal("s4_addr", board_address, 50);
      draw_busy = 1;
      runCycle();
      checkVal("s4_hold2", board_wren, 1);
      runCycle();
      checkVal("s4_hold3", board_wren, 1);
      runCycle();
      checkVal("s4_done", board_wren, 0);
      checkVal("s4_updated", board_updated, 1);
      draw_busy = 0;

      // Repeat request on the last write cycle survives the clear
      resetDut();
      redMove(3, 2);
      cycles(4);
      redMove(7, 7);
      cycles(1);
      checkVal("s5_pending", pending, 4'b0001);
      checkVal("s5_no_update", board_updated, 0);
      cycles(2);
      checkVal("s5_addr", board_address, 119);
      checkVal("s5_wren", board_wren, 1);
      cycles(3);
      checkVal("s5_updated", board_updated, 1);

      // Reset during the second write cycle
      resetDut();
      redMove(3, 2);
      cycles(3);
      checkVal("s6_wren", board_wren, 1);
      reset = 0;
      cycles(1);
      reset = 1;
      checkVal("s6_wren_off", board_wren, 0);
      checkVal("s6_pending", pending, 0);
      checkVal("s6_busy", busy, 0);
      checkVal("s6_updated", board_updated, 0);

      // Randomized traffic against the model
      resetDut();
      for (int n = 0; n < 600; n++) begin
         reset = ($urandom_range(0, 79) != 0);
         if ($urandom_range(0, 5) == 0) draw_busy = ~draw_busy;
         red_move_req   = ($urandom_range(0, 7) == 0);
         blue_move_req  = ($urandom_range(0, 7) == 0);
         redBombPlaced  = ($urandom_range(0, 11) == 0);
         blueBombPlaced = ($urandom_range(0, 11) == 0);
         red_X = 4'($urandom_range(0, 3));  red_Y = 4'($urandom_range(0, 3));
         blue_X = 4'($urandom_range(0, 3)); blue_Y = 4'($urandom_range(0, 3));
         redBomb_X = 4'($urandom);  redBomb_Y = 4'($urandom);
         blueBomb_X = 4'($urandom); blueBomb_Y = 4'($urandom);
         runCycle();
      end
      reset = 1; draw_busy = 0;
      cycles(30);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
      $finish;
   end

endmodule
